// File: rtl/tri_feeder_pkg.sv
// Shared types for the triangle feeder: FSM states, the per-triangle record and buffer depth.
package tri_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } feeder_state_t;

    localparam int BUF_DEPTH  = 2;
    localparam int REC_D_BITS = 32;
    localparam int REC_M_BITS = 32;

    typedef struct packed {
        logic [2:0][REC_D_BITS-1:0] normal;
        logic [2:0][REC_D_BITS-1:0] v0;
        logic [2:0][REC_D_BITS-1:0] v1;
        logic [2:0][REC_D_BITS-1:0] v2;
        logic [2:0][REC_D_BITS-1:0] origin;
        logic [2:0][REC_D_BITS-1:0] dir;
        logic [REC_M_BITS-1:0]      id;
    } tri_rec_t;

endpackage

// File: rtl/tri_rec_buf.sv
// Two-entry record FIFO between triangle memory read data and the output port.
// Push and pop are never issued illegally; the feeder's credit check guarantees room.
module tri_rec_buf
    import tri_feeder_pkg::*;
#(
    parameter type rec_t = tri_rec_t
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       push_i,
    input  rec_t       push_dat_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output rec_t       head_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    rec_t             mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [1:0]       count_q;

    // Storage is reset so the outputs read zero straight out of reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tri_feeder.sv
// Accepts one ray, walks triangle IDs 0..count-1 through a 1-cycle memory and pushes one record per triangle.
// Reads are issued only while buffered plus in-flight records fit in the 2-entry buffer.
module tri_feeder
    import tri_feeder_pkg::*;
#(
    parameter int D_BITS   = 32,
    parameter int M_BITS   = 32,
    parameter int MAX_TRIS = 1024,
    parameter int A_BITS   = $clog2(MAX_TRIS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [D_BITS-1:0] ray_origin [2:0],
    input  logic [D_BITS-1:0] ray_dir [2:0],
    input  logic [A_BITS:0]   ray_num_tris,
    input  logic              ray_wr_en,
    output logic              ray_full,
    output logic              mem_rd_en,
    output logic [A_BITS-1:0] mem_addr,
    input  logic [D_BITS-1:0] mem_normal [2:0],
    input  logic [D_BITS-1:0] mem_v0 [2:0],
    input  logic [D_BITS-1:0] mem_v1 [2:0],
    input  logic [D_BITS-1:0] mem_v2 [2:0],
    output logic [D_BITS-1:0] tri_normal_out [2:0],
    output logic [D_BITS-1:0] v0_out [2:0],
    output logic [D_BITS-1:0] v1_out [2:0],
    output logic [D_BITS-1:0] v2_out [2:0],
    output logic [D_BITS-1:0] origin_out [2:0],
    output logic [D_BITS-1:0] dir_out [2:0],
    output logic [M_BITS-1:0] triangle_id_out,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic              ray_done
);

    localparam int CNT_W = A_BITS + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIS);

    typedef struct packed {
        logic [2:0][D_BITS-1:0] normal;
        logic [2:0][D_BITS-1:0] v0;
        logic [2:0][D_BITS-1:0] v1;
        logic [2:0][D_BITS-1:0] v2;
        logic [2:0][D_BITS-1:0] origin;
        logic [2:0][D_BITS-1:0] dir;
        logic [M_BITS-1:0]      id;
    } rec_t;

    feeder_state_t          state_q, state_d;
    logic [2:0][D_BITS-1:0] origin_q, dir_q;
    logic [CNT_W-1:0]       count_q, issue_q, num_clamped;
    logic                   inflight_q;
    logic [A_BITS-1:0]      rd_addr_q;

    logic [1:0] buf_cnt;
    rec_t       head, rec_in;
    logic       pop, issue, buf_empty_next;
    logic [2:0] used;

    assign num_clamped = (ray_num_tris > MAX_CNT) ? MAX_CNT : ray_num_tris;

    assign pop   = (buf_cnt != 2'd0) && !out_full;
    assign used  = {1'b0, buf_cnt} + {2'b0, inflight_q};
    // A read may be issued when its record is guaranteed a slot by the time it returns.
    assign issue = (state_q == RUN) && (issue_q < count_q) && (used < 3'd2 + {2'b0, pop});
    assign buf_empty_next = (buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop);

    assign rec_in.normal = {mem_normal[2], mem_normal[1], mem_normal[0]};
    assign rec_in.v0     = {mem_v0[2], mem_v0[1], mem_v0[0]};
    assign rec_in.v1     = {mem_v1[2], mem_v1[1], mem_v1[0]};
    assign rec_in.v2     = {mem_v2[2], mem_v2[1], mem_v2[0]};
    assign rec_in.origin = origin_q;
    assign rec_in.dir    = dir_q;
    assign rec_in.id     = M_BITS'(rd_addr_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ray_wr_en) state_d = (num_clamped != '0) ? RUN : DONE;
            RUN:  if ((issue_q == count_q) && !inflight_q && buf_empty_next) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            origin_q   <= '0;
            dir_q      <= '0;
            count_q    <= '0;
            issue_q    <= '0;
            inflight_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if ((state_q == IDLE) && ray_wr_en) begin
                origin_q <= {ray_origin[2], ray_origin[1], ray_origin[0]};
                dir_q    <= {ray_dir[2], ray_dir[1], ray_dir[0]};
                count_q  <= num_clamped;
                issue_q  <= '0;
            end
            if (issue) begin
                issue_q   <= issue_q + CNT_W'(1);
                rd_addr_q <= issue_q[A_BITS-1:0];
            end
        end
    end

    tri_rec_buf #(.rec_t(rec_t)) u_buf (
        .clock_i    (clock),
        .reset_n_i  (reset),
        .push_i     (inflight_q),
        .push_dat_i (rec_in),
        .pop_i      (pop),
        .count_o    (buf_cnt),
        .head_o     (head)
    );

    assign ray_full        = (state_q != IDLE);
    assign ray_done        = (state_q == DONE);
    assign mem_rd_en       = issue;
    assign mem_addr        = issue ? issue_q[A_BITS-1:0] : '0;
    assign out_wr_en       = pop;
    assign triangle_id_out = head.id;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tri_normal_out[i] = head.normal[i];
            v0_out[i]         = head.v0[i];
            v1_out[i]         = head.v1[i];
            v2_out[i]         = head.v2[i];
            origin_out[i]     = head.origin[i];
            dir_out[i]        = head.dir[i];
        end
    end

endmodule

// File: tb/tb_tri_feeder.sv
// Directed bench for tri_feeder: table of rays with hand-computed timing plus reset-mid-ray sequence.
module tb_tri_feeder;

    localparam int D_BITS   = 32;
    localparam int M_BITS   = 32;
    localparam int MAX_TRIS = 1024;
    localparam int A_BITS   = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [D_BITS-1:0] ray_origin [2:0];
    logic [D_BITS-1:0] ray_dir [2:0];
    logic [A_BITS:0]   ray_num_tris;
    logic              ray_wr_en;
    logic              ray_full;
    logic              mem_rd_en;
    logic [A_BITS-1:0] mem_addr;
    logic [D_BITS-1:0] mem_normal [2:0];
    logic [D_BITS-1:0] mem_v0 [2:0];
    logic [D_BITS-1:0] mem_v1 [2:0];
    logic [D_BITS-1:0] mem_v2 [2:0];
    logic [D_BITS-1:0] tri_normal_out [2:0];
    logic [D_BITS-1:0] v0_out [2:0];
    logic [D_BITS-1:0] v1_out [2:0];
    logic [D_BITS-1:0] v2_out [2:0];
    logic [D_BITS-1:0] origin_out [2:0];
    logic [D_BITS-1:0] dir_out [2:0];
    logic [M_BITS-1:0] triangle_id_out;
    logic              out_wr_en;
    logic              out_full;
    logic              ray_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    tri_feeder #(
        .D_BITS(D_BITS), .M_BITS(M_BITS), .MAX_TRIS(MAX_TRIS), .A_BITS(A_BITS)
    ) dut (
        .clock(clock), .reset(reset),
        .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_num_tris(ray_num_tris),
        .ray_wr_en(ray_wr_en), .ray_full(ray_full),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_normal(mem_normal), .mem_v0(mem_v0), .mem_v1(mem_v1), .mem_v2(mem_v2),
        .tri_normal_out(tri_normal_out), .v0_out(v0_out), .v1_out(v1_out), .v2_out(v2_out),
        .origin_out(origin_out), .dir_out(dir_out), .triangle_id_out(triangle_id_out),
        .out_wr_en(out_wr_en), .out_full(out_full), .ray_done(ray_done)
    );

    // Synchronous triangle memory: word i holds i, i+1, ... i+11 across normal/v0/v1/v2.
    always @(posedge clock) begin
        if (mem_rd_en) begin
            for (int j = 0; j < 3; j++) begin
                mem_normal[j] <= 32'(mem_addr) + 32'(j);
                mem_v0[j]     <= 32'(mem_addr) + 32'(3 + j);
                mem_v1[j]     <= 32'(mem_addr) + 32'(6 + j);
                mem_v2[j]     <= 32'(mem_addr) + 32'(9 + j);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int n;
        int base;
        int bp_lo;
        int bp_hi;
        bit ovr;
        int exp_recs;
        int exp_done;
    } vec_t;

    // Cycle c is the clock period that begins at the c-th edge after the accepting edge.
    task automatic run_ray(input vec_t v);
        int recs = 0;
        int reads = 0;
        int done_c = -1;
        logic [M_BITS-1:0] frozen_id = '0;
        logic [D_BITS-1:0] frozen_nrm = '0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            ray_origin[k] = 32'(v.base + k);
            ray_dir[k]    = 32'(v.base + 16 + k);
        end
        ray_num_tris = 11'(v.n);
        ray_wr_en    = 1'b1;
        out_full     = 1'b0;
        @(posedge clock);
        for (int c = 0; c < v.n + 64 && done_c < 0; c++) begin
            if (c > 0) @(posedge clock);
            #1;
            if (c == 0) ray_wr_en = 1'b0;
            out_full = (c >= v.bp_lo) && (c <= v.bp_hi);
            if (v.ovr && c == 2) begin
                ray_wr_en = 1'b1;
                ray_num_tris = 11'd7;
                for (int k = 0; k < 3; k++) ray_origin[k] = 32'(v.base + 50 + k);
            end
            if (v.ovr && c == 3) ray_wr_en = 1'b0;
            #1;
            if (mem_rd_en) begin
                check("mem_addr", 64'(mem_addr), 64'(reads));
                reads++;
                check("reads_within_count", 64'(reads <= v.exp_recs), 64'd1);
            end
            if (out_wr_en) begin
                check("wr_while_full", 64'(out_full), 64'd0);
                check("record_id", 64'(triangle_id_out), 64'(recs));
                if (v.bp_lo < 0) check("push_cycle", 64'(c), 64'(recs + 2));
                for (int j = 0; j < 3; j++) begin
                    check("normal", 64'(tri_normal_out[j]), 64'(recs + j));
                    check("v0", 64'(v0_out[j]), 64'(recs + 3 + j));
                    check("v1", 64'(v1_out[j]), 64'(recs + 6 + j));
                    check("v2", 64'(v2_out[j]), 64'(recs + 9 + j));
                    check("origin", 64'(origin_out[j]), 64'(v.base + j));
                    check("dir", 64'(dir_out[j]), 64'(v.base + 16 + j));
                end
                recs++;
            end
            if (mem_rd_en) check("outstanding_le_2", 64'((reads - recs) <= 2), 64'd1);
            if (c == v.bp_lo) begin
                frozen_id  = triangle_id_out;
                frozen_nrm = tri_normal_out[0];
            end
            if (c > v.bp_lo && c <= v.bp_hi) begin
                check("frozen_id", 64'(triangle_id_out), 64'(frozen_id));
                check("frozen_normal", 64'(tri_normal_out[0]), 64'(frozen_nrm));
            end
            if (ray_done) done_c = c;
        end
        out_full = 1'b0;
        ray_wr_en = 1'b0;
        check("done_cycle", 64'(done_c), 64'(v.exp_done));
        check("record_count", 64'(recs), 64'(v.exp_recs));
        check("read_count", 64'(reads), 64'(v.exp_recs));
        @(posedge clock);
        #2;
        check("done_one_cycle", 64'(ray_done), 64'd0);
        check("full_released", 64'(ray_full), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        ray_wr_en    = 1'b0;
        out_full     = 1'b0;
        ray_num_tris = '0;
        for (int k = 0; k < 3; k++) begin
            ray_origin[k] = '0;
            ray_dir[k]    = '0;
        end

        #12;
        check("rst_ray_full", 64'(ray_full), 64'd0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_out_wr_en", 64'(out_wr_en), 64'd0);
        check("rst_ray_done", 64'(ray_done), 64'd0);
        check("rst_id", 64'(triangle_id_out), 64'd0);
        check("rst_origin", 64'(origin_out[2]), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        //          n     base  bp_lo bp_hi ovr recs  done
        vecs[0] = '{4,    100,  -1,   -1,   0,  4,    6};
        vecs[1] = '{0,    200,  -1,   -1,   0,  0,    0};
        vecs[2] = '{1,    300,  -1,   -1,   0,  1,    3};
        vecs[3] = '{5,    400,  3,    8,    0,  5,    13};
        vecs[4] = '{3,    500,  -1,   -1,   1,  3,    5};
        vecs[5] = '{1024, 600,  -1,   -1,   0,  1024, 1026};
        vecs[6] = '{1027, 700,  -1,   -1,   0,  1024, 1026};
        for (int i = 0; i < 7; i++) run_ray(vecs[i]);

        // Reset while record 2 of an 8-triangle ray is on the output.
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            ray_origin[k] = 32'(800 + k);
            ray_dir[k]    = 32'(816 + k);
        end
        ray_num_tris = 11'd8;
        ray_wr_en    = 1'b1;
        @(posedge clock);
        #1 ray_wr_en = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("pre_reset_wr_en", 64'(out_wr_en), 64'd1);
        check("pre_reset_id", 64'(triangle_id_out), 64'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_ray_full", 64'(ray_full), 64'd0);
        check("mid_rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_out_wr_en", 64'(out_wr_en), 64'd0);
        check("mid_rst_id", 64'(triangle_id_out), 64'd0);
        check("mid_rst_origin", 64'(origin_out[0]), 64'd0);
        check("mid_rst_dir", 64'(dir_out[1]), 64'd0);
        check("mid_rst_normal", 64'(tri_normal_out[2]), 64'd0);
        check("mid_rst_v1", 64'(v1_out[0]), 64'd0);
        repeat (2) begin
            @(posedge clock);
            #2;
            check("done_in_reset", 64'(ray_done), 64'd0);
        end
        reset = 1'b1;
        run_ray('{1, 900, -1, -1, 0, 1, 3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
